// File: rtl/branch_resolve_scheduler.sv
// branch_resolve_scheduler
// Tracks predictions issued at decode in an in-order queue, pairs each
// memory-stage resolve with its queued prediction, and drives the tournament
// predictor update port. A mispredict discards every younger (wrong-path)
// entry and raises a one-cycle flush.
// Optional feature macro: BRANCH_SCHED_STATS_EN adds stat_resolved and
// stat_mispredict counters.
module branch_resolve_scheduler #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         dec_valid,
    input  logic [ADDR_W-1:0]            dec_pc,
    input  logic                         dec_prediction,
    output logic                         dec_ready,
    input  logic                         res_valid,
    input  logic [ADDR_W-1:0]            res_pc,
    input  logic                         res_taken,
    output logic                         upd_valid,
    output logic [ADDR_W-1:0]            upd_addr,
    output logic                         upd_taken,
    output logic                         upd_mispredict,
    output logic                         flush,
    output logic                         order_err,
`ifdef BRANCH_SCHED_STATS_EN
    output logic [31:0]                  stat_resolved,
    output logic [31:0]                  stat_mispredict,
`endif
    output logic [$clog2(DEPTH):0]       occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic              pred;
    } entry_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    entry_t             head;

    logic               head_ok_c;
    logic               pop_c;
    logic               mis_c;
    logic               err_c;
    logic               push_c;

    assign head = mem[rd_ptr];

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a mispredicting pop enters FLUSH, which always lasts one cycle
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (mis_c) state_nxt = ST_FLUSH;
            ST_FLUSH: state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    // Per-cycle control decode; resolves are ignored during FLUSH
    always_comb begin
        head_ok_c = 1'b0;
        pop_c     = 1'b0;
        mis_c     = 1'b0;
        err_c     = 1'b0;
        dec_ready = 1'b0;
        push_c    = 1'b0;
        if (state == ST_RUN) begin
            head_ok_c = (occupancy != '0) && (res_pc == head.pc);
            pop_c     = res_valid && head_ok_c;
            mis_c     = pop_c && (head.pred != res_taken);
            err_c     = res_valid && !head_ok_c;
            dec_ready = (occupancy < OCC_W'(DEPTH)) || pop_c;
            // a push alongside a mispredicting pop is wrong-path and dropped
            push_c    = dec_valid && dec_ready && !mis_c;
        end
    end

    // Queue storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= '{pc: dec_pc, pred: dec_prediction};
        end
    end

    // Pointers, occupancy, predictor update and status registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            occupancy      <= '0;
            upd_valid      <= 1'b0;
            upd_addr       <= '0;
            upd_taken      <= 1'b0;
            upd_mispredict <= 1'b0;
            flush          <= 1'b0;
            order_err      <= 1'b0;
        end else begin
            upd_valid      <= pop_c;
            upd_mispredict <= mis_c;
            flush          <= mis_c;
            if (pop_c) begin
                upd_addr  <= head.pc;
                upd_taken <= res_taken;
            end
            if (err_c) begin
                order_err <= 1'b1;
            end
            if (mis_c) begin
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                occupancy <= '0;
            end else begin
                if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push_c, pop_c})
                    2'b10:   occupancy <= occupancy + OCC_W'(1);
                    2'b01:   occupancy <= occupancy - OCC_W'(1);
                    default: occupancy <= occupancy;
                endcase
            end
        end
    end

`ifdef BRANCH_SCHED_STATS_EN
    // Resolve and mispredict counters, free-running with natural wrap
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_resolved   <= '0;
            stat_mispredict <= '0;
        end else begin
            if (pop_c) stat_resolved   <= stat_resolved + 32'(1);
            if (mis_c) stat_mispredict <= stat_mispredict + 32'(1);
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_scheduler.sv
// Bench for branch_resolve_scheduler: directed scenarios followed by random
// traffic, checked against a queue-level model with a decoupled monitor.
module tb_branch_resolve_scheduler;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              dec_valid = 1'b0;
    logic [ADDR_W-1:0] dec_pc = '0;
    logic              dec_prediction = 1'b0;
    logic              dec_ready;
    logic              res_valid = 1'b0;
    logic [ADDR_W-1:0] res_pc = '0;
    logic              res_taken = 1'b0;
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_addr;
    logic              upd_taken;
    logic              upd_mispredict;
    logic              flush;
    logic              order_err;
    logic [2:0]        occupancy;
`ifdef BRANCH_SCHED_STATS_EN
    logic [31:0]       stat_resolved;
    logic [31:0]       stat_mispredict;
`endif

    branch_resolve_scheduler #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .dec_valid      (dec_valid),
        .dec_pc         (dec_pc),
        .dec_prediction (dec_prediction),
        .dec_ready      (dec_ready),
        .res_valid      (res_valid),
        .res_pc         (res_pc),
        .res_taken      (res_taken),
        .upd_valid      (upd_valid),
        .upd_addr       (upd_addr),
        .upd_taken      (upd_taken),
        .upd_mispredict (upd_mispredict),
        .flush          (flush),
        .order_err      (order_err),
`ifdef BRANCH_SCHED_STATS_EN
        .stat_resolved  (stat_resolved),
        .stat_mispredict(stat_mispredict),
`endif
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic              pred;
    } ent_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              taken;
        logic              mis;
    } upd_t;

    ent_t        mq[$];
    upd_t        exp_q[$];
    bit          m_flush;
    bit          m_err;
    int unsigned m_res;
    int unsigned m_mis;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model advances to the state after the next edge
    task automatic step(input bit dv, input logic [ADDR_W-1:0] pc, input bit pred,
                        input bit rv, input logic [ADDR_W-1:0] rpc, input bit rt);
        bit hit;
        bit exp_ready;
        bit mis;
        @(negedge clk);
        check("occupancy", 64'(occupancy), 64'(mq.size()));
        check("order_err", 64'(order_err), 64'(m_err));
`ifdef BRANCH_SCHED_STATS_EN
        check("stat_resolved", 64'(stat_resolved), 64'(m_res));
        check("stat_mispredict", 64'(stat_mispredict), 64'(m_mis));
`endif
        dec_valid      = dv;
        dec_pc         = pc;
        dec_prediction = pred;
        res_valid      = rv;
        res_pc         = rpc;
        res_taken      = rt;
        #1;
        hit       = !m_flush && rv && (mq.size() != 0) && (mq[0].pc == rpc);
        exp_ready = !m_flush && ((mq.size() < int'(DEPTH)) || hit);
        check("dec_ready", 64'(dec_ready), 64'(exp_ready));
        mis = 1'b0;
        if (m_flush) begin
            m_flush = 1'b0;
        end else begin
            if (rv && !hit) m_err = 1'b1;
            if (hit) begin
                mis = (mq[0].pred != rt);
                exp_q.push_back('{addr: rpc, taken: rt, mis: mis});
                m_res++;
                if (mis) m_mis++;
                void'(mq.pop_front());
                if (mis) begin
                    mq.delete();
                    m_flush = 1'b1;
                end
            end
            if (dv && exp_ready && !mis) mq.push_back('{pc: pc, pred: pred});
        end
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic push(input logic [ADDR_W-1:0] pc, input bit pred);
        step(1'b1, pc, pred, 1'b0, '0, 1'b0);
    endtask

    task automatic resolve(input logic [ADDR_W-1:0] pc, input bit taken);
        step(1'b0, '0, 1'b0, 1'b1, pc, taken);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset_n   = 1'b0;
        dec_valid = 1'b0;
        res_valid = 1'b0;
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        mq.delete();
        exp_q.delete();
        m_flush = 1'b0;
        m_err   = 1'b0;
        m_res   = 0;
        m_mis   = 0;
    endtask

    // Monitor: every update pulse must match the oldest expected update
    always @(negedge clk) begin
        upd_t e;
        if (reset_n) begin
            if (upd_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_upd: got upd_valid=1 addr=%0h expected no update at %0t",
                             upd_addr, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("upd_addr", 64'(upd_addr), 64'(e.addr));
                    check("upd_taken", 64'(upd_taken), 64'(e.taken));
                    check("upd_mispredict", 64'(upd_mispredict), 64'(e.mis));
                    check("flush", 64'(flush), 64'(e.mis));
                end
            end else begin
                check("flush_idle", 64'(flush), 64'(0));
            end
        end
    end

    initial begin
        logic [ADDR_W-1:0] rpc;
        bit                rt;
        bit                dv;
        bit                rv;

        do_reset();
        idle();
        idle();

        // two in-order resolves, both correctly predicted
        push(32'h10, 1'b1);
        push(32'h14, 1'b0);
        resolve(32'h10, 1'b1);
        resolve(32'h14, 1'b0);
        idle();
        idle();

        // full queue: stalled push, then push + resolve at the full boundary
        push(32'h40, 1'b1);
        push(32'h44, 1'b1);
        push(32'h48, 1'b1);
        push(32'h4c, 1'b1);
        push(32'h50, 1'b1);
        step(1'b1, 32'h54, 1'b1, 1'b1, 32'h40, 1'b1);
        idle();
        resolve(32'h44, 1'b1);
        resolve(32'h48, 1'b1);
        resolve(32'h4c, 1'b1);
        resolve(32'h54, 1'b1);
        idle();

        // push + resolve with a single entry
        push(32'h60, 1'b0);
        step(1'b1, 32'h64, 1'b0, 1'b1, 32'h60, 1'b0);
        resolve(32'h64, 1'b0);
        idle();

        // mispredict discards younger entries and the same-cycle push
        push(32'h20, 1'b1);
        push(32'h24, 1'b0);
        push(32'h28, 1'b1);
        step(1'b1, 32'h2c, 1'b0, 1'b1, 32'h20, 1'b0);
        step(1'b1, 32'h30, 1'b0, 1'b1, 32'h24, 1'b0);
        idle();

        // protocol errors: empty resolve, then wrong pc; flag is sticky
        resolve(32'h99, 1'b0);
        push(32'h34, 1'b1);
        resolve(32'h99, 1'b1);
        idle();
        resolve(32'h34, 1'b1);
        idle();

        // reset in the FLUSH cycle with entries in flight
        do_reset();
        push(32'h70, 1'b1);
        push(32'h74, 1'b1);
        resolve(32'h70, 1'b1);
        push(32'h78, 1'b0);
        resolve(32'h74, 1'b0);
        do_reset();
        idle();
        push(32'h80, 1'b1);
        push(32'h84, 1'b0);
        do_reset();
        idle();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                dv = ($urandom_range(0, 2) != 0);
                rv = ($urandom_range(0, 1) != 0);
                if ((mq.size() != 0) && ($urandom_range(0, 9) != 0)) begin
                    rpc = mq[0].pc;
                    rt  = mq[0].pred ^ ($urandom_range(0, 4) == 0);
                end else begin
                    rpc = $urandom;
                    rt  = $urandom_range(0, 1) != 0;
                end
                step(dv, ADDR_W'($urandom) & ~ADDR_W'(3), $urandom_range(0, 1) != 0,
                     rv, rpc, rt);
            end
        end

        idle();
        idle();
        idle();
        check("leftover_updates", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
